// File: rtl/axis_skid_slice.sv
// AXI-Stream register slice with a 2-entry skid buffer; both forward and ready paths registered.
// Optional packet counter enabled by defining AXIS_SKID_PKT_CNT_EN.
module axis_skid_slice #(
    parameter int DSIZE = 8,
    parameter int KSIZE = DSIZE / 8,
    parameter int USIZE = 1,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [DSIZE-1:0] axis_in_tdata,
    input  logic [KSIZE-1:0] axis_in_tkeep,
    input  logic [USIZE-1:0] axis_in_tuser,
    input  logic             axis_in_tlast,
    input  logic             axis_in_tvalid,
    output logic             axis_in_tready,
    output logic [DSIZE-1:0] axis_out_tdata,
    output logic [KSIZE-1:0] axis_out_tkeep,
    output logic [USIZE-1:0] axis_out_tuser,
    output logic             axis_out_tlast,
    output logic             axis_out_tvalid,
    input  logic             axis_out_tready,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [DSIZE-1:0] main_data, skid_data;
    logic [KSIZE-1:0] main_keep, skid_keep;
    logic [USIZE-1:0] main_user, skid_user;
    logic             main_last, skid_last;

    logic in_hs, out_hs;
    logic load_main_in, load_main_skid, load_skid, clear_main;

    assign in_hs  = axis_in_tvalid & in_ready_q;
    assign out_hs = out_valid_q & axis_out_tready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_hs && !out_hs) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (in_hs && out_hs) begin
                    load_main_in = 1'b1;
                end else if (out_hs) begin
                    clear_main = 1'b1;
                    state_nxt  = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Ready and valid are registered copies of the next-state decode, so neither
    // output has a combinational path from axis_out_tready.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            main_data <= '0;
            main_keep <= '1;
            main_user <= '0;
            main_last <= 1'b0;
            skid_data <= '0;
            skid_keep <= '1;
            skid_user <= '0;
            skid_last <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= axis_in_tdata;
                main_keep <= axis_in_tkeep;
                main_user <= axis_in_tuser;
                main_last <= axis_in_tlast;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_keep <= skid_keep;
                main_user <= skid_user;
                main_last <= skid_last;
            end else if (clear_main) begin
                main_data <= '0;
                main_keep <= '1;
                main_user <= '0;
                main_last <= 1'b0;
            end

            if (load_skid) begin
                skid_data <= axis_in_tdata;
                skid_keep <= axis_in_tkeep;
                skid_user <= axis_in_tuser;
                skid_last <= axis_in_tlast;
            end else if (load_main_skid) begin
                skid_data <= '0;
                skid_keep <= '1;
                skid_user <= '0;
                skid_last <= 1'b0;
            end
        end
    end

    assign axis_in_tready  = in_ready_q;
    assign axis_out_tvalid = out_valid_q;
    assign axis_out_tdata  = main_data;
    assign axis_out_tkeep  = main_keep;
    assign axis_out_tuser  = main_user;
    assign axis_out_tlast  = main_last;

`ifdef AXIS_SKID_PKT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (out_hs && main_last) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_skid_slice.sv
// Directed and randomized self-checking bench for axis_skid_slice (DSIZE=16, USIZE=2, CNT_W=4).
module tb_axis_skid_slice;

    localparam int DSIZE = 16;
    localparam int KSIZE = DSIZE / 8;
    localparam int USIZE = 2;
    localparam int CNT_W = 4;
    localparam int BW    = DSIZE + KSIZE + USIZE + 1;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic [DSIZE-1:0] in_tdata = '0;
    logic [KSIZE-1:0] in_tkeep = '1;
    logic [USIZE-1:0] in_tuser = '0;
    logic             in_tlast = 1'b0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic [DSIZE-1:0] out_tdata;
    logic [KSIZE-1:0] out_tkeep;
    logic [USIZE-1:0] out_tuser;
    logic             out_tlast;
    logic             out_tvalid;
    logic             out_tready = 1'b0;
    logic [CNT_W-1:0] pkt_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axis_skid_slice #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .CNT_W(CNT_W)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .axis_in_tdata  (in_tdata),
        .axis_in_tkeep  (in_tkeep),
        .axis_in_tuser  (in_tuser),
        .axis_in_tlast  (in_tlast),
        .axis_in_tvalid (in_tvalid),
        .axis_in_tready (in_tready),
        .axis_out_tdata (out_tdata),
        .axis_out_tkeep (out_tkeep),
        .axis_out_tuser (out_tuser),
        .axis_out_tlast (out_tlast),
        .axis_out_tvalid(out_tvalid),
        .axis_out_tready(out_tready),
        .pkt_cnt        (pkt_cnt)
    );

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '1;
        in_tuser   = '0;
        in_tlast   = 1'b0;
        areset     = 1'b1;
        next_cycle();
        next_cycle();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b expected 0", out_tvalid); end
        n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b expected 1", in_tready); end
        n_cmp++; if (out_tkeep !== 2'b11) begin n_err++; $display("FAIL reset_tkeep: got %b expected 11", out_tkeep); end
        n_cmp++; if (out_tdata !== 16'h0000) begin n_err++; $display("FAIL reset_tdata: got %h expected 0000", out_tdata); end
        n_cmp++; if ({out_tuser, out_tlast} !== 3'b000) begin n_err++; $display("FAIL reset_user_last: got %b expected 000", {out_tuser, out_tlast}); end
        n_cmp++; if (pkt_cnt !== 4'd0) begin n_err++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
    endtask

    task automatic test_stream();
        next_cycle();
        in_tdata   = 16'h0001;
        in_tvalid  = 1'b1;
        out_tready = 1'b1;
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL stream_latency: got tvalid %b expected 0", out_tvalid); end
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            if (i < 15) in_tdata = 16'(i + 2);
            else begin in_tvalid = 1'b0; in_tdata = '0; end
            @(negedge aclk);
            n_cmp++; if (out_tvalid !== 1'b1 || out_tdata !== 16'(i + 1)) begin
                n_err++; $display("FAIL stream_beat%0d: got v=%b d=%h expected v=1 d=%h", i, out_tvalid, out_tdata, 16'(i + 1));
            end
            n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d: got %b expected 1", i, in_tready); end
        end
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b0 || out_tdata !== 16'h0000 || out_tkeep !== 2'b11) begin
            n_err++; $display("FAIL stream_idle: got v=%b d=%h k=%b expected v=0 d=0000 k=11", out_tvalid, out_tdata, out_tkeep);
        end
        out_tready = 1'b0;
    endtask

    task automatic fill_two(input logic [15:0] a, input logic [15:0] b);
        next_cycle();
        out_tready = 1'b0;
        in_tdata   = a;
        in_tvalid  = 1'b1;
        next_cycle();
        in_tdata = b;
        next_cycle();
        in_tvalid = 1'b0;
        in_tdata  = '0;
    endtask

    task automatic test_skid_full();
        fill_two(16'h00A5, 16'h005A);
        @(negedge aclk);
        n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b expected 0", in_tready); end
        n_cmp++; if (out_tvalid !== 1'b1 || out_tdata !== 16'h00A5) begin n_err++; $display("FAIL full_hold: got v=%b d=%h expected v=1 d=00a5", out_tvalid, out_tdata); end
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tdata !== 16'h00A5 || in_tready !== 1'b0) begin n_err++; $display("FAIL full_stall: got d=%h r=%b expected d=00a5 r=0", out_tdata, in_tready); end
        out_tready = 1'b1;
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b1 || out_tdata !== 16'h005A) begin n_err++; $display("FAIL full_skid_out: got v=%b d=%h expected v=1 d=005a", out_tvalid, out_tdata); end
        n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b expected 1", in_tready); end
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b0 || out_tdata !== 16'h0000) begin n_err++; $display("FAIL full_drain: got v=%b d=%h expected v=0 d=0000", out_tvalid, out_tdata); end
        out_tready = 1'b0;
    endtask

    task automatic test_random();
        logic [BW-1:0] q[$];
        logic [BW-1:0] exp_b, got_b, held_b;
        logic          accepted = 1'b0;
        logic          stalled = 1'b0;
        int            sent = 0, got = 0, cycles = 0;
        do_reset();
        next_cycle();
        while (got < 1000 && cycles < 20000) begin
            if (!in_tvalid || accepted) begin
                if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                    in_tdata  = 16'($urandom);
                    in_tkeep  = 2'($urandom);
                    in_tuser  = 2'($urandom);
                    in_tlast  = ((sent + 1) % 7 == 0);
                    in_tvalid = 1'b1;
                end else begin
                    in_tvalid = 1'b0;
                end
            end
            out_tready = ($urandom_range(0, 1) == 1);
            @(negedge aclk);
            got_b = {out_tlast, out_tuser, out_tkeep, out_tdata};
            if (stalled) begin
                n_cmp++; if (out_tvalid !== 1'b1 || got_b !== held_b) begin
                    n_err++; $display("FAIL rand_stable: got v=%b beat=%h expected v=1 beat=%h", out_tvalid, got_b, held_b);
                end
            end
            stalled = out_tvalid && !out_tready;
            held_b  = got_b;
            accepted = in_tvalid && in_tready;
            if (accepted) begin
                q.push_back({in_tlast, in_tuser, in_tkeep, in_tdata});
                sent++;
            end
            if (out_tvalid && out_tready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got beat=%h expected none", got_b);
                end else begin
                    exp_b = q.pop_front();
                    if (got_b !== exp_b) begin n_err++; $display("FAIL rand_beat%0d: got %h expected %h", got, got_b, exp_b); end
                end
                got++;
            end
            next_cycle();
            cycles++;
        end
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        n_cmp++; if (got != 1000 || sent != 1000 || q.size() != 0) begin
            n_err++; $display("FAIL rand_count: got sent=%0d recv=%0d left=%0d expected 1000/1000/0", sent, got, q.size());
        end
    endtask

    task automatic test_pkt_cnt();
        logic [CNT_W-1:0] exp5, exp17;
`ifdef AXIS_SKID_PKT_CNT_EN
        exp5 = 4'd5; exp17 = 4'd1;
`else
        exp5 = 4'd0; exp17 = 4'd0;
`endif
        do_reset();
        next_cycle();
        out_tready = 1'b1;
        in_tlast   = 1'b1;
        in_tkeep   = '1;
        for (int i = 0; i < 17; i++) begin
            in_tdata  = 16'(i);
            in_tvalid = 1'b1;
            next_cycle();
            if (i == 4) begin
                in_tvalid = 1'b0;
                next_cycle();
                next_cycle();
                @(negedge aclk);
                n_cmp++; if (pkt_cnt !== exp5) begin n_err++; $display("FAIL pkt_cnt5: got %0d expected %0d", pkt_cnt, exp5); end
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (pkt_cnt !== exp17) begin n_err++; $display("FAIL pkt_cnt17: got %0d expected %0d", pkt_cnt, exp17); end
        out_tready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        fill_two(16'h0011, 16'h0022);
        @(negedge aclk);
        n_cmp++; if (in_tready !== 1'b0 || out_tdata !== 16'h0011) begin n_err++; $display("FAIL flush_setup: got r=%b d=%h expected r=0 d=0011", in_tready, out_tdata); end
        areset = 1'b1;
        next_cycle();
        @(negedge aclk);
        n_cmp++; if (out_tvalid !== 1'b0 || out_tdata !== 16'h0000) begin n_err++; $display("FAIL flush_out: got v=%b d=%h expected v=0 d=0000", out_tvalid, out_tdata); end
        areset     = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge aclk);
            n_cmp++; if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin
                n_err++; $display("FAIL flush_after%0d: got v=%b r=%b d=%h expected v=0 r=1", i, out_tvalid, in_tready, out_tdata);
            end
        end
        out_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_full();
        test_random();
        test_pkt_cnt();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_skid_slice.md
Name: axis_skid_slice

Overview:
- Full AXI-Stream register slice placed directly downstream of the combinational-ready slaver pipe.
- Registers the forward path (tdata/tkeep/tuser/tlast/tvalid) and the backward path (tready), using a 2-entry skid buffer.
- The pipe ahead of it passes tready straight through, so this stage ends that ready chain and gives timing closure across long datapaths.
- Sustains 1 beat/cycle. No bubbles while downstream is ready.

Parameters:
- DSIZE, 8, tdata width in bits (multiple of 8).
- KSIZE, DSIZE/8, tkeep width.
- USIZE, 1, tuser width.
- CNT_W, 16, packet counter width (used only with the optional feature).

Ports:
- aclk  in  1  stream clock, single clock domain.
- areset  in  1  synchronous reset, active-high.
- axis_in_tdata  in  DSIZE  upstream data.
- axis_in_tkeep  in  KSIZE  upstream byte enables.
- axis_in_tuser  in  USIZE  upstream user sideband.
- axis_in_tlast  in  1  upstream end-of-packet.
- axis_in_tvalid  in  1  upstream valid.
- axis_in_tready  out  1  registered ready to upstream.
- axis_out_tdata  out  DSIZE  registered data.
- axis_out_tkeep  out  KSIZE  registered byte enables.
- axis_out_tuser  out  USIZE  registered user sideband.
- axis_out_tlast  out  1  registered end-of-packet.
- axis_out_tvalid  out  1  registered valid.
- axis_out_tready  in  1  downstream ready.
- pkt_cnt  out  CNT_W  completed output packets (optional feature).

Behaviour:
- One clock (aclk). Reset is synchronous, active-high (areset), sampled on the rising edge of aclk.
- Storage: a main register, which drives the axis_out_* signals, and a skid register holding one overflow beat.
- State machine, 3 states:
  - EMPTY: no beat held.
  - BUSY: main register valid.
  - FULL: main and skid both valid.
- Handshake events: in_hs = axis_in_tvalid & axis_in_tready; out_hs = axis_out_tvalid & axis_out_tready.
- EMPTY:
  - in_hs -> capture into main, go to BUSY.
- BUSY:
  - in_hs & !out_hs -> capture into skid, go to FULL.
  - in_hs & out_hs -> capture into main, stay BUSY.
  - !in_hs & out_hs -> go to EMPTY.
  - Otherwise hold.
- FULL:
  - axis_in_tready is 0, so in_hs is impossible.
  - out_hs -> move skid into main, go to BUSY.
  - Otherwise hold.
- Output and ready rules:
  - axis_out_tvalid = (state != EMPTY).
  - axis_in_tready = (state != FULL). It is taken from a register, with no combinational path from axis_out_tready.
- Latency: 1 cycle from in_hs to axis_out_tvalid when EMPTY. Throughput: 1 beat/cycle while axis_out_tready stays high.
- Ordering: beats leave in arrival order. tdata/tkeep/tuser/tlast always move together as one beat.
- Stability: while axis_out_tvalid=1 and axis_out_tready=0, all axis_out_* signals hold constant (AXIS rule).
- Idle values: after out_hs with no replacement beat, payload registers return to tdata=0, tkeep='1, tuser=0, tlast=0.
- Reset values:
  - State EMPTY; axis_out_tvalid=0; axis_in_tready=1 from the first cycle after reset.
  - tdata=0, tkeep='1, tuser=0, tlast=0; pkt_cnt=0.
- Reset mid-operation: beats held in either register are discarded with no handshake on the output. Upstream must treat the reset as a stream flush.
- Simultaneous events:
  - In BUSY, in_hs and out_hs in the same cycle replace the main register with no bubble.
  - In FULL, the skid beat moves to main on out_hs and axis_in_tready rises the next cycle.

Optional Feature:
- Macro: AXIS_SKID_PKT_CNT_EN.
- Defined:
  - pkt_cnt increments by 1 on each out_hs with axis_out_tlast=1.
  - Wraps modulo 2^CNT_W (all-ones + 1 -> 0).
  - Cleared by areset.
- Undefined: no counter logic is built; pkt_cnt is tied to 0.

Test Plan:
- Reset, then idle -> axis_out_tvalid=0, axis_in_tready=1, tkeep=all ones, pkt_cnt=0.
- Stream 0x01..0x10 with axis_out_tready=1 throughout -> 16 output beats on consecutive cycles, first one 1 cycle after the first in_hs, data in order.
- Beat 0xA5 accepted, then 0x5A presented with axis_out_tready=0 -> FULL; axis_in_tready=0 next cycle; output holds 0xA5. Raise ready -> 0xA5 then 0x5A, and axis_in_tready returns to 1.
- Random tvalid/tready (50% each), 1000 beats, tlast every 7th beat -> output sequence equals input sequence; no drops or duplicates; outputs stable during stalls.
- With AXIS_SKID_PKT_CNT_EN and CNT_W=4: 17 single-beat packets -> pkt_cnt=1 (wrap). Without the macro -> pkt_cnt=0.
- Assert areset while FULL with 0x11/0x22 held -> next cycle axis_out_tvalid=0, tdata=0; neither beat ever appears on the output.
